// File: rtl/sb_data_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sb_data_mem_pkg                                              |
// | Description : Shared widths, byte_sel codes and FSM encodings for the      |
// |               system-bus data-memory responder.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sb_data_mem_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int MEM_ADDR_WIDTH = 32;
   localparam int BYTE_SEL       = 3;

   // RISC-V funct3 load/store size codes
   localparam logic [BYTE_SEL-1:0] SB_BYTE  = 3'b000;
   localparam logic [BYTE_SEL-1:0] SB_HALF  = 3'b001;
   localparam logic [BYTE_SEL-1:0] SB_WORD  = 3'b010;
   localparam logic [BYTE_SEL-1:0] SB_BYTEU = 3'b100;
   localparam logic [BYTE_SEL-1:0] SB_HALFU = 3'b101;

   typedef enum logic [1:0] {
      SB_IDLE = 2'b00,
      SB_BUSY = 2'b01,
      SB_DONE = 2'b10
   } sb_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } sb_size_e;

   // Unlisted codes fall back to a word access.
   function automatic sb_size_e sb_size(input logic [BYTE_SEL-1:0] sel);
      case (sel)
         SB_BYTE, SB_BYTEU: return SZ_BYTE;
         SB_HALF, SB_HALFU: return SZ_HALF;
         default:           return SZ_WORD;
      endcase
   endfunction

   function automatic logic sb_misaligned(input logic [BYTE_SEL-1:0] sel,
                                          input logic [1:0]          lo);
      case (sb_size(sel))
         SZ_HALF: return lo[0];
         SZ_WORD: return |lo;
         default: return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/sb_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sb_lane_align                                                |
// | Description : Store byte-enable/merge-data generation and load lane        |
// |               extraction with sign/zero extension (combinational).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sb_lane_align
   import sb_data_mem_pkg::*;
(
   input  logic [1:0]            addr_lo,
   input  logic [BYTE_SEL-1:0]   byte_sel,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rword,
   output logic [3:0]            wbe,
   output logic [DATA_WIDTH-1:0] wmerge,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_signed;

   assign w_byte   = rword[{addr_lo, 3'b000} +: 8];
   assign w_half   = addr_lo[1] ? rword[31:16] : rword[15:0];
   assign w_signed = ~byte_sel[2];

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      wbe    = 4'b1111;
      wmerge = wdata;
      rdata  = rword;
      case (sb_size(byte_sel))
         SZ_BYTE: begin
            wbe    = 4'b0001 << addr_lo;
            wmerge = {4{wdata[7:0]}};
            rdata  = {{24{w_signed & w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            wbe    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wmerge = {2{wdata[15:0]}};
            rdata  = {{16{w_signed & w_half[15]}}, w_half};
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/sb_data_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sb_data_mem                                                  |
// | Description : System-bus data-memory responder with programmable wait     |
// |               states. Optional macro SB_MISALIGN_CHK_EN adds misalign_o.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sb_data_mem
   import sb_data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_re_i,
   input  logic [MEM_ADDR_WIDTH-1:0] mem_raddr_i,
   input  logic                      mem_we_i,
   input  logic [MEM_ADDR_WIDTH-1:0] mem_waddr_i,
   input  logic [DATA_WIDTH-1:0]     mem_wdata_i,
   input  logic [BYTE_SEL-1:0]       byte_sel_i,
   output logic [DATA_WIDTH-1:0]     mem_rdata_o,
   output logic                      done_o,
   output logic                      hold_o
`ifdef SB_MISALIGN_CHK_EN
   ,
   output logic                      misalign_o
`endif
);

   localparam int c_IDX_W = $clog2(DEPTH_WORDS);
   localparam int c_ADR_W = c_IDX_W + 2;
   localparam int c_CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   sb_state_e                 r_state;
   sb_state_e                 w_state_nxt;
   logic [c_CNT_W-1:0]        r_cnt;
   logic                      r_is_store;
   logic [c_ADR_W-1:0]        r_addr;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic [BYTE_SEL-1:0]       r_sel;
   logic [DATA_WIDTH-1:0]     r_rdata;
   logic [DATA_WIDTH-1:0]     r_mem [DEPTH_WORDS];

   logic                      w_req;
   logic [MEM_ADDR_WIDTH-1:0] w_req_addr;
   logic                      w_idle;
   logic                      w_cur_store;
   logic [c_ADR_W-1:0]        w_cur_addr;
   logic [DATA_WIDTH-1:0]     w_cur_wdata;
   logic [BYTE_SEL-1:0]       w_cur_sel;
   logic [c_IDX_W-1:0]        w_idx;
   logic [DATA_WIDTH-1:0]     w_rword;
   logic [3:0]                w_wbe;
   logic [DATA_WIDTH-1:0]     w_wmerge;
   logic [DATA_WIDTH-1:0]     w_ld_data;
   logic                      w_accept;
   logic                      w_commit;
   logic                      w_misalign;
   logic                      w_unused_addr;

   // Store wins when both requests are raised together.
   assign w_req         = mem_re_i | mem_we_i;
   assign w_req_addr    = mem_we_i ? mem_waddr_i : mem_raddr_i;
   assign w_unused_addr = ^w_req_addr[MEM_ADDR_WIDTH-1:c_ADR_W];

   // In IDLE the live request drives the datapath so a zero-wait access can commit at once.
   assign w_idle      = (r_state == SB_IDLE);
   assign w_cur_store = w_idle ? mem_we_i                   : r_is_store;
   assign w_cur_addr  = w_idle ? w_req_addr[c_ADR_W-1:0]    : r_addr;
   assign w_cur_wdata = w_idle ? mem_wdata_i                : r_wdata;
   assign w_cur_sel   = w_idle ? byte_sel_i                 : r_sel;
   assign w_idx       = w_cur_addr[c_ADR_W-1:2];
   assign w_rword     = r_mem[w_idx];

`ifdef SB_MISALIGN_CHK_EN
   logic r_misalign;

   assign w_misalign = sb_misaligned(w_cur_sel, w_cur_addr[1:0]);
   assign misalign_o = r_misalign & (r_state == SB_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else if (w_accept) begin
         r_misalign <= w_misalign;
      end
   end
`else
   assign w_misalign = 1'b0;
`endif

   sb_lane_align u_lane_align (
      .addr_lo  (w_cur_addr[1:0]),
      .byte_sel (w_cur_sel),
      .wdata    (w_cur_wdata),
      .rword    (w_rword),
      .wbe      (w_wbe),
      .wmerge   (w_wmerge),
      .rdata    (w_ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      hold_o      = 1'b0;
      done_o      = 1'b0;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         SB_IDLE: begin
            if (w_req) begin
               hold_o   = 1'b1;
               w_accept = 1'b1;
               if (w_misalign) begin
                  w_state_nxt = SB_DONE;
               end else if (WAIT_CYCLES == 0) begin
                  w_commit    = 1'b1;
                  w_state_nxt = SB_DONE;
               end else begin
                  w_state_nxt = SB_BUSY;
               end
            end
         end
         SB_BUSY: begin
            hold_o = 1'b1;
            if (r_cnt <= c_CNT_W'(1)) begin
               w_commit    = 1'b1;
               w_state_nxt = SB_DONE;
            end
         end
         SB_DONE: begin
            done_o      = 1'b1;
            w_state_nxt = SB_IDLE;
         end
         default: w_state_nxt = SB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_is_store <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_sel      <= '0;
         r_rdata    <= '0;
      end else begin
         if (w_accept) begin
            r_cnt      <= c_CNT_W'(WAIT_CYCLES);
            r_is_store <= mem_we_i;
            r_addr     <= w_req_addr[c_ADR_W-1:0];
            r_wdata    <= mem_wdata_i;
            r_sel      <= byte_sel_i;
         end else if (r_state == SB_BUSY) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
         end
         if (w_accept && w_misalign) begin
            r_rdata <= '0;
         end else if (w_commit && !w_cur_store) begin
            r_rdata <= w_ld_data;
         end
      end
   end

   // RAM contents survive reset; a store still in flight when rst rises is dropped.
   always_ff @(posedge clk) begin
      if (!rst && w_commit && w_cur_store) begin
         for (int i = 0; i < 4; i++) begin
            if (w_wbe[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_wmerge[8*i +: 8];
            end
         end
      end
   end

   assign mem_rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sb_data_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sb_data_mem                                               |
// | Description : Directed self-checking bench; instance 0 has one wait state, |
// |               instance 1 has three wait states and a 64-word RAM.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sb_data_mem;
   import sb_data_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst   [2];
   logic        re    [2];
   logic        we    [2];
   logic [31:0] raddr [2];
   logic [31:0] waddr [2];
   logic [31:0] wdata [2];
   logic [2:0]  sel   [2];
   logic [31:0] rdata [2];
   logic        done  [2];
   logic        hold  [2];
   logic        misal [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sb_data_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst[0]), .mem_re_i(re[0]), .mem_raddr_i(raddr[0]),
      .mem_we_i(we[0]), .mem_waddr_i(waddr[0]), .mem_wdata_i(wdata[0]),
      .byte_sel_i(sel[0]), .mem_rdata_o(rdata[0]), .done_o(done[0]), .hold_o(hold[0])
`ifdef SB_MISALIGN_CHK_EN
      , .misalign_o(misal[0])
`endif
   );

   sb_data_mem #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst[1]), .mem_re_i(re[1]), .mem_raddr_i(raddr[1]),
      .mem_we_i(we[1]), .mem_waddr_i(waddr[1]), .mem_wdata_i(wdata[1]),
      .byte_sel_i(sel[1]), .mem_rdata_o(rdata[1]), .done_o(done[1]), .hold_o(hold[1])
`ifdef SB_MISALIGN_CHK_EN
      , .misalign_o(misal[1])
`endif
   );

`ifndef SB_MISALIGN_CHK_EN
   assign misal[0] = 1'b0;
   assign misal[1] = 1'b0;
`endif

   // Called and returns at posedge+1; waits (bounded) for done and releases the request in DONE.
   task automatic access(input int k, input logic st, input logic ld,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] bs, output logic [31:0] rd,
                         output int lat, output int holds, output logic mis);
      we[k] = st; re[k] = ld; waddr[k] = addr; raddr[k] = addr;
      wdata[k] = data; sel[k] = bs;
      lat = 0; holds = 0;
      #1;
      while (done[k] !== 1'b1 && lat < 16) begin
         if (hold[k] === 1'b1) holds++;
         @(posedge clk); #1;
         lat++;
      end
      rd  = rdata[k];
      mis = misal[k];
      if (done[k] !== 1'b1) begin
         checks++; errors++;
         $display("FAIL timeout k=%0d addr=%h: done_o never seen in 16 cycles", k, addr);
      end
      we[k] = 1'b0; re[k] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; re[k] = 1'b0; we[k] = 1'b0;
         raddr[k] = '0; waddr[k] = '0; wdata[k] = '0; sel[k] = SB_WORD;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (rdata[k] !== 32'h0 || done[k] !== 1'b0 || hold[k] !== 1'b0 || misal[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state k=%0d: rdata=%h done=%b hold=%b mis=%b, required 0/0/0/0",
                     k, rdata[k], done[k], hold[k], misal[k]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      logic [31:0] rd; int lat; int holds; logic mis;
      access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, SB_WORD, rd, lat, holds, mis);
      checks++;
      if (lat !== 2 || holds !== 2) begin
         errors++;
         $display("FAIL sw_timing: latency=%0d hold_cycles=%0d, required 2/2", lat, holds);
      end
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL sw_rdata_unchanged: rdata=%h, required 00000000", rd);
      end
      access(0, 1'b0, 1'b1, 32'h10, 32'h0, SB_WORD, rd, lat, holds, mis);
      checks++;
      if (lat !== 2 || holds !== 2) begin
         errors++;
         $display("FAIL lw_timing: latency=%0d hold_cycles=%0d, required 2/2", lat, holds);
      end
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL lw_0x10: rdata=%h, required deadbeef", rd);
      end
   endtask

   task automatic test_byte();
      logic [31:0] rd; int lat; int holds; logic mis;
      access(0, 1'b1, 1'b0, 32'h13, 32'h00000080, SB_BYTE, rd, lat, holds, mis);
      access(0, 1'b0, 1'b1, 32'h13, 32'h0, SB_BYTE, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'hFFFFFF80) begin
         errors++;
         $display("FAIL lb_0x13: rdata=%h, required ffffff80", rd);
      end
      access(0, 1'b0, 1'b1, 32'h13, 32'h0, SB_BYTEU, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'h00000080) begin
         errors++;
         $display("FAIL lbu_0x13: rdata=%h, required 00000080", rd);
      end
      access(0, 1'b0, 1'b1, 32'h10, 32'h0, SB_WORD, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'h80ADBEEF) begin
         errors++;
         $display("FAIL lw_after_sb: rdata=%h, required 80adbeef", rd);
      end
      access(0, 1'b0, 1'b1, 32'h11, 32'h0, SB_BYTE, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'hFFFFFFBE) begin
         errors++;
         $display("FAIL lb_0x11: rdata=%h, required ffffffbe", rd);
      end
   endtask

   task automatic test_half();
      logic [31:0] rd; int lat; int holds; logic mis;
      access(0, 1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, SB_WORD, rd, lat, holds, mis);
      access(0, 1'b1, 1'b0, 32'h22, 32'hABCD1234, SB_HALF, rd, lat, holds, mis);
      access(0, 1'b0, 1'b1, 32'h22, 32'h0, SB_HALF, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'h00001234) begin
         errors++;
         $display("FAIL lh_0x22: rdata=%h, required 00001234", rd);
      end
      access(0, 1'b0, 1'b1, 32'h20, 32'h0, SB_HALF, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL lh_0x20: rdata=%h, required ffffffff", rd);
      end
      access(0, 1'b0, 1'b1, 32'h20, 32'h0, SB_HALFU, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'h0000FFFF) begin
         errors++;
         $display("FAIL lhu_0x20: rdata=%h, required 0000ffff", rd);
      end
      access(0, 1'b0, 1'b1, 32'h20, 32'h0, SB_WORD, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'h1234FFFF) begin
         errors++;
         $display("FAIL lw_0x20: rdata=%h, required 1234ffff", rd);
      end
   endtask

   task automatic test_both();
      logic [31:0] rd; int lat; int holds; logic mis;
      int pulses;
      pulses = 0;
      we[0] = 1'b1; re[0] = 1'b1; waddr[0] = 32'h30; raddr[0] = 32'h10;
      wdata[0] = 32'h5; sel[0] = SB_WORD;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done[0] === 1'b1) begin
            pulses++;
            we[0] = 1'b0; re[0] = 1'b0;
         end
      end
      we[0] = 1'b0; re[0] = 1'b0;
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL both_done_pulses: pulses=%0d, required 1", pulses);
      end
      checks++;
      if (rdata[0] !== 32'h1234FFFF) begin
         errors++;
         $display("FAIL both_no_load: rdata=%h, required 1234ffff", rdata[0]);
      end
      access(0, 1'b0, 1'b1, 32'h30, 32'h0, SB_WORD, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'h00000005) begin
         errors++;
         $display("FAIL lw_0x30: rdata=%h, required 00000005", rd);
      end
   endtask

   task automatic test_reset_busy();
      logic [31:0] rd; int lat; int holds; logic mis;
      int pulses;
      access(1, 1'b1, 1'b0, 32'h40, 32'h11223344, SB_WORD, rd, lat, holds, mis);
      access(1, 1'b0, 1'b1, 32'h40, 32'h0, SB_WORD, rd, lat, holds, mis);
      checks++;
      if (lat !== 4 || holds !== 4 || rd !== 32'h11223344) begin
         errors++;
         $display("FAIL w3_lw: latency=%0d hold_cycles=%0d rdata=%h, required 4/4/11223344",
                  lat, holds, rd);
      end
      we[1] = 1'b1; waddr[1] = 32'h40; wdata[1] = 32'hCAFEF00D; sel[1] = SB_WORD;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (hold[1] !== 1'b1 || done[1] !== 1'b0) begin
         errors++;
         $display("FAIL w3_busy: hold=%b done=%b, required 1/0", hold[1], done[1]);
      end
      rst[1] = 1'b1; we[1] = 1'b0;
      @(posedge clk); #1;
      rst[1] = 1'b0;
      #1;
      checks++;
      if (hold[1] !== 1'b0 || done[1] !== 1'b0 || rdata[1] !== 32'h0) begin
         errors++;
         $display("FAIL rst_busy_outputs: hold=%b done=%b rdata=%h, required 0/0/00000000",
                  hold[1], done[1], rdata[1]);
      end
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (done[1] === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL rst_busy_no_done: pulses=%0d, required 0", pulses);
      end
      access(1, 1'b0, 1'b1, 32'h40, 32'h0, SB_WORD, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'h11223344) begin
         errors++;
         $display("FAIL rst_store_dropped: rdata=%h, required 11223344", rd);
      end
      access(1, 1'b0, 1'b1, 32'h140, 32'h0, SB_WORD, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'h11223344) begin
         errors++;
         $display("FAIL addr_wrap_0x140: rdata=%h, required 11223344", rd);
      end
   endtask

`ifdef SB_MISALIGN_CHK_EN
   task automatic test_misalign();
      logic [31:0] rd; int lat; int holds; logic mis;
      access(0, 1'b1, 1'b0, 32'h40, 32'h5555AAAA, SB_WORD, rd, lat, holds, mis);
      access(0, 1'b1, 1'b0, 32'h43, 32'h0, SB_WORD, rd, lat, holds, mis);
      access(0, 1'b0, 1'b1, 32'h41, 32'h0, SB_WORD, rd, lat, holds, mis);
      checks++;
      if (lat !== 1 || mis !== 1'b1 || rd !== 32'h0) begin
         errors++;
         $display("FAIL lw_0x41_misalign: latency=%0d mis=%b rdata=%h, required 1/1/00000000",
                  lat, mis, rd);
      end
      access(0, 1'b0, 1'b1, 32'h40, 32'h0, SB_WORD, rd, lat, holds, mis);
      checks++;
      if (rd !== 32'h5555AAAA || mis !== 1'b0) begin
         errors++;
         $display("FAIL misalign_ram_kept: rdata=%h mis=%b, required 5555aaaa/0", rd, mis);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_both();
      test_reset_busy();
`ifdef SB_MISALIGN_CHK_EN
      test_misalign();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
